// File: rtl/flappy_pkg.sv
// Shared widths, screen geometry and game state encoding
// for the flappy pipe pipeline.
package flappy_pkg;

    localparam int X_W      = 11;
    localparam int Y_W      = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int RND_MAX  = 348;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One scrolling pipe obstacle: occupancy, right-edge x and gap top,
// with a flag raised when a move carries the pipe across the bird column.
module pipe_slot
    import flappy_pkg::*;
#(
    parameter int STEP   = 2,
    parameter int BIRD_X = 160
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           load,
    input  logic           move,
    input  logic           kill,
    input  logic [X_W-1:0] load_x,
    input  logic [Y_W-1:0] load_gap,
    output logic           valid,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] gap,
    output logic           crossed
);

    logic           valid_q, valid_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] gap_q, gap_d;
    logic [X_W-1:0] x_moved;

    assign x_moved = x_q - X_W'(STEP);

    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        gap_d   = gap_q;
        if (clr) begin
            valid_d = 1'b0;
            x_d     = '0;
            gap_d   = '0;
        end else if (load) begin
            valid_d = 1'b1;
            x_d     = load_x;
            gap_d   = load_gap;
        end else if (kill) begin
            valid_d = 1'b0;
            x_d     = '0;
            gap_d   = '0;
        end else if (move) begin
            x_d = x_moved;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            gap_q   <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            gap_q   <= gap_d;
        end
    end

    assign crossed = move && valid_q && !kill
                     && (x_q > X_W'(BIRD_X))
                     && (x_moved <= X_W'(BIRD_X));

    assign valid = valid_q;
    assign x     = x_q;
    assign gap   = gap_q;

endmodule

// File: rtl/pipe_spawner.sv
// Pipe pool manager: run/halt state machine, spacing-driven spawning
// into the lowest free slot, per-tick scrolling and score pulse.
module pipe_spawner
    import flappy_pkg::*;
#(
    parameter int N_PIPES  = 4,
    parameter int SCREEN_W = 640,
    parameter int PIPE_W   = 52,
    parameter int SPACING  = 200,
    parameter int STEP     = 2,
    parameter int GAP_MIN  = 10,
    parameter int GAP_H    = 120,
    parameter int BIRD_X   = 160
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   run,
    input  logic                   clear,
    input  logic [9:0]             rnd,
    output logic [N_PIPES-1:0]     pipe_valid,
    output logic [N_PIPES*11-1:0]  pipe_x,
    output logic [N_PIPES*10-1:0]  pipe_gap,
    output logic                   score_pulse,
    output logic                   overflow
);

    if (GAP_MIN + RND_MAX + GAP_H >= SCREEN_H) begin : g_bad_gap
        $error("pipe gap can extend below the screen");
    end

    localparam logic [X_W-1:0] SPAWN_X = X_W'(SCREEN_W + PIPE_W);

    state_e         state_q, state_d;
    logic [X_W-1:0] dist_q, dist_d;
    logic           score_pulse_q, score_pulse_d;
    logic           overflow_q, overflow_d;

    logic [N_PIPES-1:0] slot_valid;
    logic [N_PIPES-1:0] slot_load;
    logic [N_PIPES-1:0] slot_move;
    logic [N_PIPES-1:0] slot_kill;
    logic [N_PIPES-1:0] slot_crossed;
    logic [X_W-1:0]     slot_x [N_PIPES];
    logic [Y_W-1:0]     slot_gap [N_PIPES];

    logic           advance;
    logic           spawn_due;
    logic           any_free;
    logic [Y_W-1:0] new_gap;

    // A tick only counts while running, or when it starts the round from IDLE.
    assign advance = tick && run
                     && ((state_q == IDLE) || (state_q == RUN));
    assign spawn_due = dist_q >= X_W'(SPACING);
    assign new_gap   = Y_W'(GAP_MIN) + rnd;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (tick && run) state_d = RUN;
                RUN:     if (!run) state_d = HALT;
                HALT:    if (run) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Free is judged on pre-tick occupancy, so a slot dying now stays empty.
    always_comb begin
        slot_load = '0;
        any_free  = 1'b0;
        for (int i = 0; i < N_PIPES; i++) begin
            if (!slot_valid[i] && !any_free) begin
                any_free = 1'b1;
                if (advance && spawn_due) slot_load[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PIPES; i++) begin
            slot_kill[i] = advance && slot_valid[i]
                           && (slot_x[i] <= X_W'(STEP));
            slot_move[i] = advance && slot_valid[i] && !slot_kill[i];
        end
    end

    always_comb begin
        dist_d        = dist_q;
        overflow_d    = overflow_q;
        score_pulse_d = 1'b0;
        if (clear) begin
            dist_d     = X_W'(SPACING);
            overflow_d = 1'b0;
        end else if (advance) begin
            score_pulse_d = |slot_crossed;
            if (spawn_due) begin
                if (any_free) dist_d = X_W'(STEP);
                else          overflow_d = 1'b1;
            end else begin
                dist_d = dist_q + X_W'(STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dist_q        <= X_W'(SPACING);
            score_pulse_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            dist_q        <= dist_d;
            score_pulse_q <= score_pulse_d;
            overflow_q    <= overflow_d;
        end
    end

    for (genvar i = 0; i < N_PIPES; i++) begin : g_slot
        pipe_slot #(
            .STEP   (STEP),
            .BIRD_X (BIRD_X)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .clr      (clear),
            .load     (slot_load[i]),
            .move     (slot_move[i]),
            .kill     (slot_kill[i]),
            .load_x   (SPAWN_X),
            .load_gap (new_gap),
            .valid    (slot_valid[i]),
            .x        (slot_x[i]),
            .gap      (slot_gap[i]),
            .crossed  (slot_crossed[i])
        );
        assign pipe_x[11*i +: 11]   = slot_x[i];
        assign pipe_gap[10*i +: 10] = slot_gap[i];
    end

    assign pipe_valid  = slot_valid;
    assign score_pulse = score_pulse_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pipe_spawner.sv
// Directed bench: a 4-slot and a 2-slot pool driven by the same
// stimulus, checked against hand-computed positions.
module tb_pipe_spawner;

    logic       clk = 1'b0;
    logic       rst, tick, run, clear;
    logic [9:0] rnd;

    logic [3:0]  v4;
    logic [43:0] x4;
    logic [39:0] g4;
    logic        sp4, ov4;
    logic [1:0]  v2;
    logic [21:0] x2;
    logic [19:0] g2;
    logic        sp2, ov2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_spawner #(.N_PIPES(4)) u_dut4 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear),
        .rnd(rnd), .pipe_valid(v4), .pipe_x(x4), .pipe_gap(g4),
        .score_pulse(sp4), .overflow(ov4)
    );

    pipe_spawner #(.N_PIPES(2)) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear),
        .rnd(rnd), .pipe_valid(v2), .pipe_x(x2), .pipe_gap(g2),
        .score_pulse(sp2), .overflow(ov2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] px4(input int i);
        return x4[11*i +: 11];
    endfunction

    function automatic logic [9:0] pg4(input int i);
        return g4[10*i +: 10];
    endfunction

    task automatic tick_once(input logic [9:0] r);
        tick = 1'b1;
        rnd  = r;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; run = 1'b0; clear = 1'b0; rnd = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            tick = ~tick;
            run  = ~run;
        end
        rst = 1'b0; tick = 1'b0; run = 1'b0;
        chk("rst_valid4", 32'(v4), 0);
        chk("rst_x4", 32'(x4 != '0), 0);
        chk("rst_gap4", 32'(g4 != '0), 0);
        chk("rst_score", 32'(sp4), 0);
        chk("rst_ovf4", 32'(ov4), 0);
        chk("rst_valid2", 32'(v2), 0);
        chk("rst_ovf2", 32'(ov2), 0);

        idle(2);
        chk("idle_no_tick", 32'(v4), 0);

        run = 1'b1;
        tick_once(10'd100);
        chk("t0_valid4", 32'(v4), 32'b0001);
        chk("t0_x0", 32'(px4(0)), 692);
        chk("t0_gap0", 32'(pg4(0)), 110);
        chk("t0_valid2", 32'(v2), 32'b01);

        for (int k = 1; k <= 50; k++) tick_once(10'd0);
        chk("t50_x0", 32'(px4(0)), 592);

        run = 1'b0;
        idle(1);
        for (int k = 0; k < 10; k++) tick_once(10'd0);
        chk("halt_x0", 32'(px4(0)), 592);
        chk("halt_valid", 32'(v4), 32'b0001);
        run = 1'b1;
        idle(1);

        for (int k = 51; k <= 99; k++) tick_once(10'd0);
        chk("t99_x0", 32'(px4(0)), 494);
        tick_once(10'd300);
        chk("t100_x0", 32'(px4(0)), 492);
        chk("t100_x1", 32'(px4(1)), 692);
        chk("t100_gap1", 32'(pg4(1)), 310);
        chk("t100_valid4", 32'(v4), 32'b0011);

        idle(5);
        chk("hold_x0", 32'(px4(0)), 492);
        chk("hold_x1", 32'(px4(1)), 692);

        for (int k = 101; k <= 199; k++) tick_once(10'd0);
        tick_once(10'd50);
        chk("t200_valid4", 32'(v4), 32'b0111);
        chk("t200_x2", 32'(px4(2)), 692);
        chk("t200_gap2", 32'(pg4(2)), 60);
        chk("t200_ovf4", 32'(ov4), 0);
        chk("t200_ovf2", 32'(ov2), 1);
        chk("t200_valid2", 32'(v2), 32'b11);

        for (int k = 201; k <= 265; k++) tick_once(10'd0);
        chk("t265_score", 32'(sp4), 0);
        tick_once(10'd0);
        chk("t266_x0", 32'(px4(0)), 160);
        chk("t266_score4", 32'(sp4), 1);
        chk("t266_score2", 32'(sp2), 1);
        idle(1);
        chk("t266_score_drop", 32'(sp4), 0);

        for (int k = 267; k <= 345; k++) tick_once(10'd0);
        chk("t345_x0", 32'(px4(0)), 2);
        tick_once(10'd0);
        chk("t346_valid4", 32'(v4), 32'b1110);
        chk("t346_valid2", 32'(v2), 32'b10);
        chk("t346_ovf2", 32'(ov2), 1);
        tick_once(10'd77);
        chk("t347_valid2", 32'(v2), 32'b11);
        chk("t347_x2_0", 32'(x2[10:0]), 692);
        chk("t347_gap2_0", 32'(g2[9:0]), 87);
        chk("t347_valid4", 32'(v4), 32'b1110);

        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clr_valid4", 32'(v4), 0);
        chk("clr_valid2", 32'(v2), 0);
        chk("clr_ovf2", 32'(ov2), 0);
        chk("clr_x4", 32'(x4 != '0), 0);
        tick_once(10'd5);
        chk("respawn_valid", 32'(v4), 32'b0001);
        chk("respawn_x0", 32'(px4(0)), 692);
        chk("respawn_gap0", 32'(pg4(0)), 15);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_spawner.md
Name: pipe_spawner

Overview:
Consumer side of the random-height source. Samples the free-running 10-bit random value (range 0..348) whenever a new pipe spawns. Maintains a small pool of scrolling pipe obstacles (right-edge x position, gap top y) that advances once per frame tick. Feeds the renderer and collision logic, and emits a one-cycle score pulse each time a pipe passes the bird column.

Parameters:
N_PIPES, 4, number of pipe slots
SCREEN_W, 640, visible width in pixels
PIPE_W, 52, pipe width; spawn right edge = SCREEN_W+PIPE_W
SPACING, 200, horizontal distance between spawns (multiple of STEP)
STEP, 2, pixels scrolled per tick
GAP_MIN, 10, added to random value to form gap top (10+348+GAP_H < 480)
GAP_H, 120, gap height (informational, passed to renderer)
BIRD_X, 160, bird column for scoring

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle frame-advance pulse
run  in  1  level; game active
clear  in  1  one-cycle pulse; empty pool for new round
rnd  in  10  random value, 0..348
pipe_valid  out  N_PIPES  slot occupied
pipe_x  out  N_PIPES*11  per-slot right-edge x, slot i at [11i+10:11i]
pipe_gap  out  N_PIPES*10  per-slot gap top y
score_pulse  out  1  one-cycle pulse, pipe crossed BIRD_X
overflow  out  1  sticky; spawn deferred for lack of free slot

Behaviour:
- Single clock: clk. Reset rst is synchronous and active-high. Priority: rst > clear > tick.
- rst or clear:
  - all slots invalid, x=0, gap=0
  - dist=SPACING
  - score_pulse=0
  - state=IDLE
  - overflow cleared by rst and by clear
- All outputs are registered. Effects of a tick sampled at edge E are visible after E. Cycles without tick hold all state.
- FSM:
  - IDLE -> RUN on tick with run=1 (that tick is processed as a RUN tick).
  - RUN -> HALT when run=0, checked every cycle.
  - HALT -> RUN on run=1.
  - HALT ignores tick; pipes freeze.
  - clear returns to IDLE from any state.
- RUN tick, per valid slot, using pre-tick values:
  - if x <= STEP, the slot is invalidated;
  - else x <= x-STEP.
  - If old x > BIRD_X and new x <= BIRD_X, score_pulse=1 for one cycle. Multiple crossings on one tick still give a single pulse.
- RUN tick, spawn:
  - If dist >= SPACING and a slot is free, load the lowest-index free slot: valid=1, x=SCREEN_W+PIPE_W (not moved this tick), gap=GAP_MIN+rnd sampled at that edge. Then dist <= STEP.
  - Free means invalid before this tick. A slot freed on this same tick is not reused until the next tick.
  - If dist >= SPACING and no slot is free: overflow=1, dist holds, retry every tick.
  - Otherwise dist <= dist+STEP.
- Widths: x is 11-bit unsigned and never goes negative. gap is 10-bit; rnd > 348 is not expected, and the sum is not clamped. dist register is 11 bits.

Decomposition:
- Shared package flappy_pkg holds:
  - X_W=11, Y_W=10
  - SCREEN_W, SCREEN_H=480
  - RND_MAX=348
  - state typedef {IDLE, RUN, HALT}
- One sub-module, pipe_slot: valid/x/gap registers with load, move, and kill inputs, plus a crossed-BIRD_X output. Instantiated N_PIPES times. Spawn and FSM logic live in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with tick/run toggling -> all valid=0, x=0, gap=0, score_pulse=0, overflow=0.
- First spawn: run=1, tick #0 with rnd=100 -> slot0 valid, x=692, gap=110; slots 1..3 invalid.
- Spacing/scroll: continue ticks, rnd=300 at tick #100 -> slot0 x=492, slot1 x=692, gap=310. No tick for 5 cycles -> no change.
- Score and exit:
  - tick #266 -> slot0 x=160 and score_pulse high exactly one cycle.
  - tick #345 -> slot0 x=2.
  - tick #346 -> slot0 invalid.
- Overflow with N_PIPES=2:
  - tick #200 -> overflow=1, no load.
  - tick #346 frees slot0 but no load that tick.
  - tick #347 -> slot0 reloaded with x=692.
- Halt/clear:
  - run=0 at tick #50 -> x frozen over 10 ticks; run=1 resumes from the same x.
  - clear mid-run -> all invalid, IDLE; next tick with run=1 spawns immediately into slot0.
